// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cellbist6.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__cellbist6.sv - exhaustive-pattern BIST with Galois signature for a six-input cell
//
// Sweeps all 64 input patterns of a six-input cell and compresses the cell
// response into a Galois LFSR signature. The result is then compared against
// a golden value.
//
// Ports:
//   CLK      rising-edge clock
//   RN       asynchronous active-low reset
//   START    run request (ignored while a run is in progress)
//   ABORT    synchronous abort to IDLE; has priority over START
//   PAT      stimulus {A1,A2,B1,B2,C1,C2}, MSB = A1
//   ZN       cell response, LAT cycles behind PAT
//   EXP_SIG  golden signature
//   SIG      current signature
//   BUSY     high in RUN or DRAIN
//   DONE     high in DONE
//   PASS     registered SIG == EXP_SIG, valid while DONE = 1

module gf180mcu_fd_sc_mcu9t5v0__cellbist6 #(
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h8016,
    parameter logic [SIG_W-1:0]  SEED  = '0,
    parameter int                LAT   = 0
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              START,
    input  logic              ABORT,
    output logic [5:0]        PAT,
    input  logic              ZN,
    input  logic [SIG_W-1:0]  EXP_SIG,
    output logic [SIG_W-1:0]  SIG,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam bit         HAS_DRAIN = (LAT > 0);
    localparam logic [6:0] LAT_P     = 7'(LAT);
    localparam logic [1:0] LAT_M1    = 2'(LAT - 1);

    state_t             state, state_nx;
    logic [5:0]         pat_nx;
    logic [SIG_W-1:0]   sig_nx;
    logic [SIG_W-1:0]   sig_step;
    logic [SIG_W-1:0]   sig_cap;
    logic [1:0]         drain_cnt, drain_nx;
    logic               busy_nx, done_nx, pass_nx;
    logic [6:0]         pat_rel;
    logic               capture;

    // The response to pattern k arrives during RUN cycle k+LAT. The first LAT
    // RUN cycles therefore see no valid response. Every DRAIN cycle does.
    // When pat - LAT goes negative, bit 6 is set.
    assign pat_rel  = {1'b0, PAT} - LAT_P;
    assign capture  = ((state == S_RUN) && !pat_rel[6]) || (state == S_DRAIN);

    assign sig_step = {SIG[SIG_W-2:0], ZN} ^ (SIG[SIG_W-1] ? POLY : '0);
    assign sig_cap  = capture ? sig_step : SIG;

    always_comb begin
        state_nx = state;
        pat_nx   = PAT;
        sig_nx   = SIG;
        drain_nx = drain_cnt;
        done_nx  = DONE;
        pass_nx  = PASS;

        if (ABORT) begin
            state_nx = S_IDLE;
            pat_nx   = '0;
            sig_nx   = SEED;
            drain_nx = '0;
            done_nx  = 1'b0;
            pass_nx  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pat_nx = '0;
                    if (START) begin
                        state_nx = S_RUN;
                        sig_nx   = SEED;
                    end
                end
                S_RUN: begin
                    sig_nx = sig_cap;
                    if (PAT == 6'd63) begin
                        if (HAS_DRAIN) begin
                            state_nx = S_DRAIN;
                            drain_nx = '0;
                        end else begin
                            state_nx = S_DONE;
                            pat_nx   = '0;
                            done_nx  = 1'b1;
                            pass_nx  = (sig_cap == EXP_SIG);
                        end
                    end else begin
                        pat_nx = PAT + 6'd1;
                    end
                end
                S_DRAIN: begin
                    sig_nx = sig_cap;
                    if (drain_cnt == LAT_M1) begin
                        state_nx = S_DONE;
                        pat_nx   = '0;
                        done_nx  = 1'b1;
                        pass_nx  = (sig_cap == EXP_SIG);
                    end else begin
                        drain_nx = drain_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    pat_nx = '0;
                    if (START) begin
                        state_nx = S_RUN;
                        sig_nx   = SEED;
                        done_nx  = 1'b0;
                        pass_nx  = 1'b0;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    pat_nx   = '0;
                    sig_nx   = SEED;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                end
            endcase
        end

        busy_nx = (state_nx == S_RUN) || (state_nx == S_DRAIN);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= S_IDLE;
            PAT       <= '0;
            SIG       <= SEED;
            drain_cnt <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            state     <= state_nx;
            PAT       <= pat_nx;
            SIG       <= sig_nx;
            drain_cnt <= drain_nx;
            BUSY      <= busy_nx;
            DONE      <= done_nx;
            PASS      <= pass_nx;
        end
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__cellbist6.md
GF180MCU_FD_SC_MCU9T5V0__CELLBIST6 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__cellbist6

Interface
REQ-001 The block SHALL have parameter SIG_W, default 16, meaning signature register width (legal range 8..32).
REQ-002 The block SHALL have parameter POLY, default 16'h8016, meaning Galois feedback polynomial mask (SIG_W bits).
REQ-003 The block SHALL have parameter SEED, default 0, meaning signature value loaded at run start.
REQ-004 The block SHALL have parameter LAT, default 0, meaning DUT response latency in cycles (legal range 0..3).
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: CLK  input  1  rising-edge clock.
REQ-006 The block SHALL have RN  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have START  input  1  run request, sampled on the CLK rising edge.
REQ-008 The block SHALL have ABORT  input  1  synchronous abort, sampled on the CLK rising edge.
REQ-009 The block SHALL have PAT  output  6  stimulus driving {A1,A2,B1,B2,C1,C2} of a six-input cell, MSB=A1.
REQ-010 The block SHALL have ZN  input  1  cell response.
REQ-011 The block SHALL have EXP_SIG  input  SIG_W  expected golden signature.
REQ-012 The block SHALL have SIG  output  SIG_W  current signature.
REQ-013 The block SHALL have BUSY  output  1  high in RUN or DRAIN.
REQ-014 The block SHALL have DONE  output  1  high in DONE state.
REQ-015 The block SHALL have PASS  output  1  registered SIG==EXP_SIG compare, valid while DONE=1.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-017 In IDLE, START=1 SHALL move to RUN, load SIG<=SEED, and set PAT<=0.
REQ-018 In RUN, PAT SHALL increment by 1 per cycle; after the cycle with PAT=63, the FSM SHALL go to DRAIN if LAT>0, else to DONE.
REQ-019 PAT SHALL hold at 63 during DRAIN, and SHALL return to 0 in IDLE and DONE.
REQ-020 ZN SHALL be captured on each edge ending RUN cycle k+LAT for pattern k, giving exactly 64 captures per run; DRAIN SHALL last LAT cycles.
REQ-021 Each capture SHALL update SIG <= (SIG<<1) ^ (SIG[SIG_W-1] ? POLY : 0) ^ ZN (ZN into bit 0); no update SHALL occur on non-capture edges.
REQ-022 With START sampled at edge E0, DONE SHALL rise after edge E(64+LAT), and BUSY SHALL be high for exactly 64+LAT cycles.
REQ-023 On entry to DONE, PASS SHALL be registered from the final SIG, and SIG SHALL hold.
REQ-024 In DONE, DONE, PASS and SIG SHALL hold until START or ABORT.
REQ-025 START=1 in DONE SHALL restart directly into RUN (same actions as REQ-017), and DONE/PASS SHALL clear on that edge.
REQ-026 START SHALL be ignored in RUN and DRAIN.
REQ-027 ABORT=1 SHALL take any state to IDLE on the next edge, with PAT=0, SIG=SEED, DONE=0, PASS=0.
REQ-028 ABORT SHALL take priority over START when both are high on the same edge.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 RN=0 SHALL immediately force state IDLE, PAT=0, SIG=SEED, BUSY=0, DONE=0, PASS=0, including when reset is asserted mid-run.
REQ-031 After RN rises, the first START SHALL be honoured no earlier than the first CLK edge.

Verification
REQ-032 SEED=0, LAT=0, ZN=0 constant, EXP_SIG=0, START pulse -> DONE after 64 cycles, SIG=0x0000, PASS=1.
REQ-033 ZN=1 only when PAT=63 (LAT=0) -> SIG=0x0001; ZN=1 only when PAT=62 -> SIG=0x0002; with EXP_SIG=0, PASS=0.
REQ-034 LAT=2, with ZN driven from PAT via a 2-stage pipeline of an AOI222 model (ZN=!(A1&A2|B1&B2|C1&C2)), EXP_SIG from the bench software model -> BUSY for 66 cycles, PASS=1; a fault injected on pattern 0x3F -> PASS=0.
REQ-035 ABORT at RUN cycle 10 together with START -> IDLE next edge, PAT=0, no DONE; a later START completes normally.
REQ-036 RN pulse low at RUN cycle 30 -> outputs reset asynchronously without waiting for CLK; back-to-back START in DONE -> immediate rerun with an identical SIG.
